regsrc_pipe_sel: RTL
====================

# regsrc_pipe_sel

Parametrised, registered successor to the register-file write-data source selector. Picks one of `N_SRC` data sources by `sel`, with slot 0 hard-wired to the constant `CONST_VAL` (stack-pointer init value). It registers the result together with its destination register address and hands it to the register-file write port over a valid/ready handshake. A one-entry skid buffer lets it absorb back-pressure without losing a selection, and a sticky flag reports illegal selects.

## Interface
- `DATA_W`, 32, data width of every source and of the output.
- `N_SRC`, 8, number of source slots, 2..16; slot 0 is the constant.
- `SEL_W`, 3, width of `sel`; must satisfy 2^SEL_W >= N_SRC.
- `ADDR_W`, 5, destination register address width.
- `CONST_VAL`, 227, value returned for slot 0 and for illegal selects.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers `sel`/`data_in`/`dest_addr`.
- `in_ready`  out  1  block can accept this cycle.
- `sel`  in  SEL_W  source index.
- `data_in`  in  N_SRC*DATA_W  packed sources; slot k = bits [k*DATA_W +: DATA_W]; slot 0 bits ignored.
- `dest_addr`  in  ADDR_W  destination register of this write.
- `out_valid`  out  1  `out_data`/`out_addr` hold a pending write.
- `out_ready`  in  1  register file consumes the write.
- `out_data`  out  DATA_W  selected value.
- `out_addr`  out  ADDR_W  destination carried with the data.
- `sel_err`  out  1  sticky: an accepted `sel` was >= N_SRC.
- `err_clr`  in  1  synchronous clear of `sel_err`.

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- Selection is evaluated at accept time:
  - `sel==0`: value = CONST_VAL.
  - `1 <= sel < N_SRC`: value = slot `sel`.
  - `sel >= N_SRC`: value = CONST_VAL and `sel_err` is set.
- CONST_VAL is truncated or zero-extended to DATA_W.
- Storage: output register (OUT) and skid register (SKID). State machine:
  - EMPTY: accept -> ONE.
  - ONE, no accept: `out_ready` -> EMPTY; otherwise stay.
  - ONE, accept: with `out_ready`, the new entry replaces OUT and the state stays ONE; without `out_ready`, the new entry goes to SKID -> FULL.
  - FULL: no accept possible (`in_ready=0`). `out_ready` -> SKID moves to OUT -> ONE.
- `in_ready` = (state != FULL), driven from a register, never combinational from `out_ready`.
- `out_valid` = (state != EMPTY). `out_data`/`out_addr` are stable while `out_valid && !out_ready`.
- Order is strictly preserved: FIFO of depth 2.
- `sel_err`:
  - Set on an accept with an illegal sel.
  - Cleared by `err_clr`.
  - If set and clear happen in the same cycle, set wins.
- Reset asserted: the state returns to EMPTY immediately, and any pending or skid entry is discarded.
- Reset values: `out_valid=0`, `in_ready=1` after release (0 during reset), `out_data=0`, `out_addr=0`, `sel_err=0`.

## Timing
- Latency: accept at edge N -> `out_valid=1` with the selected data after edge N.
- Throughput: 1 write/cycle while `out_ready=1`.
- Source data is sampled only at accept; later changes to `data_in` do not affect a held entry.
- On the first edge after `reset_n` rises, the block may accept.
- Reset asserted mid-transfer clears `out_valid` asynchronously, without waiting for a clock edge.

## Test plan
- Reset, then accept `sel=0` with all sources = 0xFFFFFFFF -> next cycle `out_data=227`, `out_valid=1`, `sel_err=0`.
- Slot sweep: source k = 0x1000+k for k=1..7, with `sel=1..7` on back-to-back cycles and `out_ready=1` -> `out_data` = 0x1001..0x1007 in order, one per cycle; `out_addr` follows `dest_addr`.
- Back-pressure: hold `out_ready=0` and offer 3 writes (A=sel 2, B=sel 3, C=sel 4):
  - A and B are accepted; `in_ready` drops after B; C is held upstream.
  - OUT = A, stable across stall cycles.
  - Raise `out_ready` -> the bench observes A, B, C in order, with no loss or duplication.
- Illegal select: with N_SRC=5, accept `sel=6` -> `out_data=227` and `sel_err=1`, which stays set across 10 further legal writes.
  - `err_clr` in the same cycle as another illegal accept -> `sel_err` stays 1.
  - `err_clr` alone -> `sel_err` returns to 0.
- Reset mid-operation: in FULL state, pull `reset_n` low between edges -> `out_valid=0` and `out_data=0` immediately.
  - After release, a single write with sel 1 is the only output seen.
- Parameter instance with DATA_W=16, N_SRC=4, SEL_W=2, CONST_VAL=0x1_00E3 -> slot 0 returns 0x00E3; slot 3 data passes through intact.

Source files
------------

// File: rtl/regsrc_pipe_sel_if.sv
// Write-data handshake bundle between an upstream selector client, regsrc_pipe_sel
// and the register-file write port.
interface regsrc_pipe_sel_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 8,
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC*DATA_W-1:0] data_in;
  logic [ADDR_W-1:0]       dest_addr;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [ADDR_W-1:0]       out_addr;
  logic                    sel_err;
  logic                    err_clr;

  modport master (
    output in_valid, sel, data_in, dest_addr, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_addr, sel_err
  );

  modport slave (
    input  in_valid, sel, data_in, dest_addr, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_addr, sel_err
  );
endinterface

// File: rtl/regsrc_pipe_sel.sv
// Registered register-file write-data source selector with a one-entry skid buffer
// (two-deep FIFO) and a sticky illegal-select flag.
module regsrc_pipe_sel #(
  parameter int          DATA_W    = 32,
  parameter int          N_SRC     = 8,
  parameter int          SEL_W     = 3,
  parameter int          ADDR_W    = 5,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic             clk,
  input  logic             reset_n,
  regsrc_pipe_sel_if.slave bus
);

  localparam logic [DATA_W-1:0] CONST_W = DATA_W'(CONST_VAL);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_nxt;

  logic              in_rdy_q;
  logic              sel_err_q;
  logic              acc_p0;
  logic              ill_p0;
  logic [DATA_W-1:0] new_data_p0;
  logic              load_out, load_skid, skid_to_out;

  logic [DATA_W-1:0] out_data_p1, skid_data_p1;
  logic [ADDR_W-1:0] out_addr_p1, skid_addr_p1;

  // Slot 0 and any index past the last slot both yield the constant.
  function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0]        s,
                                             input logic [N_SRC*DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    v = CONST_W;
    for (int k = 0; k < N_SRC; k++) begin
      if (k != 0 && int'(s) == k) v = d[k*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  function automatic logic illegal(input logic [SEL_W-1:0] s);
    return int'(s) >= N_SRC;
  endfunction

  // Stage p0: selection evaluated on the accepted request
  assign acc_p0      = bus.in_valid & bus.in_ready;
  assign ill_p0      = illegal(bus.sel);
  assign new_data_p0 = pick(bus.sel, bus.data_in);

  always_comb begin
    state_nxt   = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc_p0) begin
          load_out  = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc_p0) begin
          if (bus.out_ready) begin
            load_out = 1'b1;
          end else begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end
        end else if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          skid_to_out = 1'b1;
          state_nxt   = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      in_rdy_q  <= 1'b1;
      sel_err_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      in_rdy_q <= (state_nxt != FULL);
      if (acc_p0 && ill_p0) begin
        sel_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        sel_err_q <= 1'b0;
      end
    end
  end

  // Stage p1: output register, cleared by reset so nothing stale is presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_p1 <= '0;
      out_addr_p1 <= '0;
    end else if (load_out) begin
      out_data_p1 <= new_data_p0;
      out_addr_p1 <= bus.dest_addr;
    end else if (skid_to_out) begin
      out_data_p1 <= skid_data_p1;
      out_addr_p1 <= skid_addr_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= new_data_p0;
      skid_addr_p1 <= bus.dest_addr;
    end
  end

  // in_ready comes from a register; reset_n only masks it while reset is held.
  assign bus.in_ready  = in_rdy_q & reset_n;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = out_data_p1;
  assign bus.out_addr  = out_addr_p1;
  assign bus.sel_err   = sel_err_q;

endmodule
